// File: rtl/keypad_bcd_entry_pkg.sv
// Shared definitions for the keypad BCD entry block.
// Contents: named key codes, debounce FSM state encoding, the 4x4 keypad
// map (indexed [row][col], col0 = leftmost column) and a digit helper.
package keypad_bcd_entry_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;  // clear entry
  localparam logic [3:0] KEY_B    = 4'hB;  // backspace
  localparam logic [3:0] KEY_STAR = 4'hE;  // '*', no entry effect
  localparam logic [3:0] KEY_HASH = 4'hF;  // '#', request load

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } kp_state_e;

  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // True for codes that enter a decimal digit.
  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_bcd_entry_key_debounce.sv
// Keypad scanner and debouncer.
// Drives one column low at a time, samples the synchronized rows once per
// column slot, and accepts a key after DEBOUNCE_SCANS consecutive samples of
// the same row on a frozen column. A held key must read idle for
// DEBOUNCE_SCANS samples before scanning resumes.
// Ports:
//   clk, nreset  : system clock, asynchronous active-low reset
//   row_i        : raw active-low keypad rows (asynchronous)
//   col_o        : one-hot-low column drive (registered)
//   key_valid    : one-cycle registered accept pulse
//   key_code     : code of the last accepted key (registered)
//   key_accept   : combinational accept strobe, high the cycle before key_valid
//   accept_code  : code being accepted, meaningful while key_accept is high
module key_debounce
  import keypad_bcd_entry_pkg::*;
#(
  parameter int SCAN_DIV       = 16384,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_accept,
  output logic [3:0] accept_code
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_ZERO = SLOT_W'(0);
  localparam logic [DB_W-1:0]   DB_DONE   = DB_W'(DEBOUNCE_SCANS);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(0);

  logic [3:0]        row_meta_r;
  logic [3:0]        row_sync_r;
  logic [SLOT_W-1:0] slot_cnt_r;
  kp_state_e         state_r;
  kp_state_e         state_s;
  logic [DB_W-1:0]   db_cnt_r;
  logic [DB_W-1:0]   db_cnt_s;
  logic [1:0]        cand_row_r;
  logic [1:0]        cand_row_s;
  logic [3:0]        col_r;
  logic [3:0]        col_s;
  logic              key_valid_r;
  logic [3:0]        key_code_r;
  logic [3:0]        key_code_s;
  logic              sample_s;
  logic              hit_s;
  logic [1:0]        hit_row_s;
  logic [1:0]        col_idx_s;
  logic              advance_s;
  logic              accept_s;

  // The last cycle of each slot is the sample point.
  assign sample_s = (slot_cnt_r == SLOT_LAST);

  // Row synchronizer and free-running slot counter.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      row_meta_r <= 4'b1111;
      row_sync_r <= 4'b1111;
      slot_cnt_r <= SLOT_ZERO;
    end else begin
      row_meta_r <= row_i;
      row_sync_r <= row_meta_r;
      slot_cnt_r <= sample_s ? SLOT_ZERO : (slot_cnt_r + SLOT_ONE);
    end
  end

  // Sample classification: exactly one low row is a hit; idle and ghost
  // (several rows low) both fall to the default and count as idle.
  always_comb begin
    hit_s     = 1'b0;
    hit_row_s = 2'd0;
    case (row_sync_r)
      4'b1110: begin hit_s = 1'b1; hit_row_s = 2'd0; end
      4'b1101: begin hit_s = 1'b1; hit_row_s = 2'd1; end
      4'b1011: begin hit_s = 1'b1; hit_row_s = 2'd2; end
      4'b0111: begin hit_s = 1'b1; hit_row_s = 2'd3; end
      default: begin hit_s = 1'b0; hit_row_s = 2'd0; end
    endcase
  end

  // Index of the column currently driven low.
  always_comb begin
    col_idx_s = 2'd0;
    case (col_r)
      4'b1110: col_idx_s = 2'd0;
      4'b1101: col_idx_s = 2'd1;
      4'b1011: col_idx_s = 2'd2;
      4'b0111: col_idx_s = 2'd3;
      default: col_idx_s = 2'd0;
    endcase
  end

  // Next-state logic; only sample points can move the FSM.
  always_comb begin
    state_s    = state_r;
    db_cnt_s   = db_cnt_r;
    cand_row_s = cand_row_r;
    advance_s  = 1'b0;
    accept_s   = 1'b0;
    if (sample_s) begin
      case (state_r)
        ST_SCAN: begin
          if (hit_s) begin
            state_s    = ST_DEBOUNCE;
            cand_row_s = hit_row_s;
            db_cnt_s   = DB_ONE;
          end else begin
            advance_s = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (hit_s && (hit_row_s == cand_row_r)) begin
            if ((db_cnt_r + DB_ONE) == DB_DONE) begin
              accept_s = 1'b1;
              state_s  = ST_HELD;
              db_cnt_s = DB_ZERO;
            end else begin
              db_cnt_s = db_cnt_r + DB_ONE;
            end
          end else begin
            state_s   = ST_SCAN;
            db_cnt_s  = DB_ZERO;
            advance_s = 1'b1;
          end
        end
        ST_HELD: begin
          // Any hit on the frozen column, even another row, restarts the
          // release count, so a second key cannot end the hold.
          if (hit_s) begin
            db_cnt_s = DB_ZERO;
          end else if ((db_cnt_r + DB_ONE) == DB_DONE) begin
            state_s   = ST_SCAN;
            db_cnt_s  = DB_ZERO;
            advance_s = 1'b1;
          end else begin
            db_cnt_s = db_cnt_r + DB_ONE;
          end
        end
        default: begin
          state_s   = ST_SCAN;
          db_cnt_s  = DB_ZERO;
          advance_s = 1'b1;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Output next-values: column rotation and accepted key code.
  always_comb begin
    col_s       = col_r;
    key_code_s  = key_code_r;
    accept_code = KEY_MAP[cand_row_r][col_idx_s];
    if (advance_s) begin
      col_s = {col_r[2:0], col_r[3]};
    end else begin
      col_s = col_r;
    end
    if (accept_s) begin
      key_code_s = accept_code;
    end else begin
      key_code_s = key_code_r;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r     <= ST_SCAN;
      db_cnt_r    <= DB_ZERO;
      cand_row_r  <= 2'd0;
      col_r       <= 4'b1110;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
    end else begin
      state_r     <= state_s;
      db_cnt_r    <= db_cnt_s;
      cand_row_r  <= cand_row_s;
      col_r       <= col_s;
      key_valid_r <= accept_s;
      key_code_r  <= key_code_s;
    end
  end

  assign col_o      = col_r;
  assign key_valid  = key_valid_r;
  assign key_code   = key_code_r;
  assign key_accept = accept_s;

endmodule

// File: rtl/keypad_bcd_entry.sv
// Keypad BCD entry: scans a 4x4 keypad and builds a 4-digit BCD value used
// to preset the 0-9999 counter.
// Ports:
//   clk, nreset : system clock, asynchronous active-low reset
//   row_i       : raw active-low keypad rows
//   col_o       : one-hot-low column drive
//   key_valid   : one-cycle pulse per accepted key
//   key_code    : last accepted key code
//   bcd_o       : entered value {thousands,hundreds,tens,ones}
//   load_o      : one-cycle pulse when '#' is accepted
module keypad_bcd_entry
  import keypad_bcd_entry_pkg::*;
#(
  parameter int SCAN_DIV       = 16384,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [3:0]  row_i,
  output logic [3:0]  col_o,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] bcd_o,
  output logic        load_o
);

  logic        accept_s;
  logic [3:0]  accept_code_s;
  logic [15:0] bcd_r;
  logic [15:0] bcd_s;
  logic        load_r;
  logic        load_s;

  key_debounce #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_key_debounce (
    .clk         (clk),
    .nreset      (nreset),
    .row_i       (row_i),
    .col_o       (col_o),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_accept  (accept_s),
    .accept_code (accept_code_s)
  );

  // Entry editing; uses the pre-register strobe so bcd_o and load_o change
  // on the same edge that raises key_valid.
  always_comb begin
    bcd_s  = bcd_r;
    load_s = 1'b0;
    if (accept_s) begin
      if (is_digit(accept_code_s)) begin
        bcd_s = {bcd_r[11:0], accept_code_s};
      end else begin
        case (accept_code_s)
          KEY_A:    bcd_s = 16'h0000;
          KEY_B:    bcd_s = {4'h0, bcd_r[15:4]};
          KEY_HASH: load_s = 1'b1;
          default:  bcd_s = bcd_r;
        endcase
      end
    end else begin
      bcd_s = bcd_r;
    end
  end

  // Entry register and load strobe.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bcd_r  <= 16'h0000;
      load_r <= 1'b0;
    end else begin
      bcd_r  <= bcd_s;
      load_r <= load_s;
    end
  end

  assign bcd_o  = bcd_r;
  assign load_o = load_r;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Self-checking bench for keypad_bcd_entry (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// A keypad model turns a 16-bit pressed-key mask into row levels from the
// driven column; the entry value is modelled as a decimal integer.
module tb_keypad_bcd_entry;

  logic        clk = 1'b0;
  logic        nreset;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] bcd_o;
  logic        load_o;

  logic [15:0] pressed = 16'h0000;   // bit r*4+c = key at row r, column c

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int load_cnt  = 0;
  int dbl_cnt   = 0;
  int digit_err_cnt = 0;
  logic prev_valid = 1'b0;
  logic prev_load  = 1'b0;
  int cyc = 0;
  int model_val = 0;
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  keypad_bcd_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .row_i     (row_i),
    .col_o     (col_o),
    .key_valid (key_valid),
    .key_code  (key_code),
    .bcd_o     (bcd_o),
    .load_o    (load_o)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a row is pulled low when a pressed key sits on a low column.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_i[r] = ~|(pressed[r*4 +: 4] & ~col_o);
    end
  end

  // Edges since reset release; slot sample decisions happen when cyc%4==0.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Pulse counters and invariant violation counters.
  always @(negedge clk) begin
    if (!nreset) begin
      prev_valid <= 1'b0;
      prev_load  <= 1'b0;
    end else begin
      if (key_valid) valid_cnt <= valid_cnt + 1;
      if (load_o)    load_cnt  <= load_cnt + 1;
      if ((key_valid && prev_valid) || (load_o && prev_load)) dbl_cnt <= dbl_cnt + 1;
      if (bcd_o[3:0] > 4'd9 || bcd_o[7:4] > 4'd9 || bcd_o[11:8] > 4'd9 || bcd_o[15:12] > 4'd9)
        digit_err_cnt <= digit_err_cnt + 1;
      prev_valid <= key_valid;
      prev_load  <= load_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_bcd();
    return {4'(model_val / 1000 % 10), 4'(model_val / 100 % 10),
            4'(model_val / 10 % 10), 4'(model_val % 10)};
  endfunction

  function automatic void model_apply(input int code);
    if (code <= 9)        model_val = (model_val * 10 + code) % 10000;
    else if (code == 10)  model_val = 0;
    else if (code == 11)  model_val = model_val / 10;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic find_pos(input int code, output int idx);
    idx = 0;
    for (int i = 0; i < 16; i++) if (keymap[i] == code) idx = i;
  endtask

  // Wait (bounded) for the accept pulse and check code, load and entry.
  task automatic wait_accept(input int code);
    int seen;
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      tick(1);
      if (key_valid) seen = 1;
    end
    chk("accept_seen", seen, 1);
    if (seen != 0) begin
      model_apply(code);
      chk("key_code", 32'(key_code), code);
      chk("load_o", 32'(load_o), (code == 15) ? 1 : 0);
      chk("bcd_o", 32'(bcd_o), 32'(model_bcd()));
    end
  endtask

  task automatic release_and_resume();
    logic [3:0] c0;
    pressed = 16'h0000;
    tick(40);
    c0 = col_o;
    tick(4);
    chk("scan_resume", 32'(col_o != c0), 1);
  endtask

  task automatic do_key(input int code, input int hold);
    int idx, v0, l0;
    find_pos(code, idx);
    v0 = valid_cnt;
    l0 = load_cnt;
    pressed[idx] = 1'b1;
    wait_accept(code);
    tick(hold);
    release_and_resume();
    chk("one_pulse", valid_cnt - v0, 1);
    chk("load_count", load_cnt - l0, (code == 15) ? 1 : 0);
  endtask

  initial begin
    int edges, v0, l0, idx;
    logic [3:0] exp_col;

    nreset = 1'b1;
    #2 nreset = 1'b0;
    tick(3);
    chk("rst_col", 32'(col_o), 32'h0000_000E);
    chk("rst_valid", 32'(key_valid), 0);
    chk("rst_code", 32'(key_code), 0);
    chk("rst_bcd", 32'(bcd_o), 0);
    chk("rst_load", 32'(load_o), 0);

    // Idle scanning: one column step per 4-clock slot.
    @(negedge clk) nreset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (k % 4 == 0) begin
        exp_col = ~(4'b0001 << ((k / 4) % 4));
        chk("rotate", 32'(col_o), 32'(exp_col));
      end
    end
    chk("idle_no_valid", valid_cnt, 0);

    // Key '5' held from reset release: column 1 is driven after edge 4, the
    // first hit sample is edge 8, the third identical sample is edge 16.
    nreset = 1'b0;
    tick(2);
    pressed[5] = 1'b1;
    @(negedge clk) nreset = 1'b1;
    edges = 0;
    for (int i = 1; i <= 40 && edges == 0; i++) begin
      tick(1);
      if (key_valid) edges = i;
    end
    chk("latency_5", edges, 16);
    model_val = 0;
    model_apply(5);
    chk("code_5", 32'(key_code), 5);
    chk("bcd_5", 32'(bcd_o), 32'h0005);
    tick(80);
    release_and_resume();
    chk("single_5", valid_cnt, 1);

    // Digit shifting, backspace and clear.
    do_key(10, 8);
    for (int d = 1; d <= 5; d++) do_key(d, 8);
    chk("bcd_2345", 32'(bcd_o), 32'h2345);
    do_key(11, 8);
    chk("bcd_0234", 32'(bcd_o), 32'h0234);
    do_key(10, 8);
    chk("bcd_clear", 32'(bcd_o), 32'h0000);

    // Load request.
    do_key(9, 8);
    do_key(8, 8);
    do_key(15, 8);
    chk("bcd_0098", 32'(bcd_o), 32'h0098);

    // Bouncing '7': the row alternates on every sample, never 3 in a row.
    v0 = valid_cnt;
    for (int i = 0; i < 4 && (cyc % 4) != 1; i++) tick(1);
    for (int i = 0; i < 16; i++) begin
      pressed[8] = ~pressed[8];
      tick(4);
    end
    @(negedge clk);
    chk("bounce_quiet", valid_cnt - v0, 0);
    pressed[8] = 1'b1;
    wait_accept(7);
    tick(20);
    release_and_resume();
    chk("bounce_single", valid_cnt - v0, 1);

    // Ghost: '5' and '8' share column 1.
    v0 = valid_cnt;
    pressed[5] = 1'b1;
    pressed[9] = 1'b1;
    tick(100);
    chk("ghost_quiet", valid_cnt - v0, 0);
    release_and_resume();

    // Random keys against the decimal model.
    for (int n = 0; n < 30; n++) begin
      tick($urandom_range(0, 12));
      do_key($urandom_range(0, 15), $urandom_range(4, 24));
    end

    // Reset while held.
    do_key(10, 8);
    do_key(4, 8);
    do_key(2, 8);
    chk("bcd_0042", 32'(bcd_o), 32'h0042);
    find_pos(12, idx);
    pressed[idx] = 1'b1;
    wait_accept(12);
    tick(10);
    #2 nreset = 1'b0;
    #1;
    chk("arst_col", 32'(col_o), 32'h0000_000E);
    chk("arst_valid", 32'(key_valid), 0);
    chk("arst_code", 32'(key_code), 0);
    chk("arst_bcd", 32'(bcd_o), 0);
    chk("arst_load", 32'(load_o), 0);
    model_val = 0;
    pressed = 16'h0000;
    tick(3);
    @(negedge clk) nreset = 1'b1;
    #1;
    chk("restart_col", 32'(col_o), 32'h0000_000E);
    v0 = valid_cnt;
    l0 = load_cnt;
    tick(60);
    chk("restart_no_valid", valid_cnt - v0, 0);
    chk("restart_no_load", load_cnt - l0, 0);

    chk("no_double_pulse", dbl_cnt, 0);
    chk("digits_in_range", digit_err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
